// File: rtl/logic_unit_pipe_pkg.sv
// Shared opcode definitions for the pipelined bitwise logic unit.
package lu_pkg;

  localparam int LU_OP_W = 3;

  localparam logic [LU_OP_W-1:0] LU_AND  = 3'b000;
  localparam logic [LU_OP_W-1:0] LU_OR   = 3'b001;
  localparam logic [LU_OP_W-1:0] LU_XOR  = 3'b010;
  localparam logic [LU_OP_W-1:0] LU_NOR  = 3'b011;
  localparam logic [LU_OP_W-1:0] LU_NAND = 3'b100;
  localparam logic [LU_OP_W-1:0] LU_XNOR = 3'b101;
  localparam logic [LU_OP_W-1:0] LU_ANDN = 3'b110;
  localparam logic [LU_OP_W-1:0] LU_PASS = 3'b111;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Upstream operand channel and downstream result channel of the logic unit.
// The unit itself is the slave; whoever drives operands and consumes results
// is the master.
interface logic_unit_pipe_if #(
  parameter int N = 8
);
  import lu_pkg::*;

  logic               i_valid;
  logic               o_ready;
  logic [LU_OP_W-1:0] i_op;
  logic [N-1:0]       i_x;
  logic [N-1:0]       i_y;

  logic               o_valid;
  logic               i_ready;
  logic [N-1:0]       o_z;
  logic               o_zero;
  logic               o_ones;

  modport slave (
    input  i_valid, i_op, i_x, i_y, i_ready,
    output o_ready, o_valid, o_z, o_zero, o_ones
  );

  modport master (
    output i_valid, i_op, i_x, i_y, i_ready,
    input  o_ready, o_valid, o_z, o_zero, o_ones
  );

endinterface

// File: rtl/logic_unit_pipe_reg.sv
// One valid/ready register slice. Ready looks straight through to the next
// stage, so a full chain of these stalls combinationally with no skid storage.
module lu_pipe_reg #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  assign o_ready = !o_valid || i_ready;

  // Load when empty or draining; data only moves with a valid beat so the
  // held value stays quiet through bubbles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (o_ready) begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit: operands are registered, the op is
// evaluated between the slices, and the result plus its flags are registered.
module logic_unit_pipe
  import lu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  logic_unit_pipe_if.slave bus
);

  localparam int S1_W = LU_OP_W + 2 * N;
  localparam int S2_W = N + 2;

  logic               s1_valid;
  logic               s2_ready;
  logic [S1_W-1:0]    s1_data;
  logic [LU_OP_W-1:0] s1_op;
  logic [N-1:0]       s1_x;
  logic [N-1:0]       s1_y;
  logic [N-1:0]       z_next;
  logic               zero_next;
  logic               ones_next;
  logic [S2_W-1:0]    s2_data;

  lu_pipe_reg #(.W(S1_W)) u_s1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (bus.i_valid),
    .o_ready (bus.o_ready),
    .i_data  ({bus.i_op, bus.i_x, bus.i_y}),
    .o_valid (s1_valid),
    .i_ready (s2_ready),
    .o_data  (s1_data)
  );

  assign {s1_op, s1_x, s1_y} = s1_data;

  // Op decode on the registered operands; every code is defined.
  always_comb begin
    z_next = '0;
    case (s1_op)
      LU_AND:  z_next = s1_x & s1_y;
      LU_OR:   z_next = s1_x | s1_y;
      LU_XOR:  z_next = s1_x ^ s1_y;
      LU_NOR:  z_next = ~(s1_x | s1_y);
      LU_NAND: z_next = ~(s1_x & s1_y);
      LU_XNOR: z_next = ~(s1_x ^ s1_y);
      LU_ANDN: z_next = s1_x & ~s1_y;
      LU_PASS: z_next = s1_x;
      default: z_next = '0;
    endcase
  end

  assign zero_next = (z_next == '0);
  assign ones_next = &z_next;

  lu_pipe_reg #(.W(S2_W)) u_s2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (s1_valid),
    .o_ready (s2_ready),
    .i_data  ({z_next, zero_next, ones_next}),
    .o_valid (bus.o_valid),
    .i_ready (bus.i_ready),
    .o_data  (s2_data)
  );

  assign {bus.o_z, bus.o_zero, bus.o_ones} = s2_data;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Drives identical traffic into N=1, N=8 and N=32 copies of the logic unit and
// checks all three every cycle against an in-flight queue model.
module tb_logic_unit_pipe;
  import lu_pkg::*;

  localparam int NW = 3;
  localparam int WID [NW] = '{1, 8, 32};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tb_valid;
  logic        tb_ready;
  logic [2:0]  tb_op;
  logic [31:0] tb_x;
  logic [31:0] tb_y;

  logic [NW-1:0] ov, ordy, zf, of;
  logic [31:0]   z_w [NW];

  int n_cmp = 0;
  int n_bad = 0;

  // hops: 1 = operands captured, 2 = result presented at the output
  typedef struct {
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    int          hops;
  } ent_t;
  ent_t q[$];

  logic m_ovalid;
  logic m_oready;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NW; g++) begin : g_w
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
    logic_unit_pipe_if #(.N(W)) bus ();
    assign bus.i_valid = tb_valid;
    assign bus.i_ready = tb_ready;
    assign bus.i_op    = tb_op;
    assign bus.i_x     = tb_x[W-1:0];
    assign bus.i_y     = tb_y[W-1:0];
    logic_unit_pipe #(.N(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
    );
    assign ov[g]   = bus.o_valid;
    assign ordy[g] = bus.o_ready;
    assign zf[g]   = bus.o_zero;
    assign of[g]   = bus.o_ones;
    assign z_w[g]  = 32'(bus.o_z);
  end

  function automatic logic [31:0] ref_op(logic [2:0] op, logic [31:0] x, logic [31:0] y);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x | y);
      3'd4:    return ~(x & y);
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return x;
    endcase
  endfunction

  function automatic logic [31:0] wmask(int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  task automatic chk(string nm, int w, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (N=%0d) at %0t: got %h, want %h", nm, w, $time, act, exp);
    end
  endtask

  // Present inputs mid-cycle and check every instance against the model.
  task automatic drive_check(input logic v, input logic r, input logic [2:0] op,
                             input logic [31:0] x, input logic [31:0] y);
    logic        s1_busy;
    logic [31:0] e;
    @(negedge clk);
    tb_valid = v;
    tb_ready = r;
    tb_op    = op;
    tb_x     = x;
    tb_y     = y;
    #1;
    m_ovalid = (q.size() > 0) && (q[0].hops == 2);
    s1_busy  = 1'b0;
    foreach (q[k]) if (q[k].hops == 1) s1_busy = 1'b1;
    m_oready = !s1_busy || !m_ovalid || r;
    for (int i = 0; i < NW; i++) begin
      chk("o_valid", WID[i], 32'(ov[i]), 32'(m_ovalid));
      chk("o_ready", WID[i], 32'(ordy[i]), 32'(m_oready));
      if (m_ovalid) begin
        e = ref_op(q[0].op, q[0].x, q[0].y) & wmask(WID[i]);
        chk("o_z", WID[i], z_w[i], e);
        chk("o_zero", WID[i], 32'(zf[i]), 32'(e == 32'd0));
        chk("o_ones", WID[i], 32'(of[i]), 32'(e == wmask(WID[i])));
      end
    end
  endtask

  // Advance the model across the next rising edge.
  task automatic commit(output logic in_x);
    logic out_x;
    out_x = m_ovalid && tb_ready;
    in_x  = tb_valid && m_oready;
    @(posedge clk);
    if (out_x) void'(q.pop_front());
    if (q.size() > 0 && q[0].hops == 1) q[0].hops = 2;
    if (in_x) q.push_back('{tb_op, tb_x, tb_y, 1});
  endtask

  task automatic step(input logic v, input logic r, input logic [2:0] op,
                      input logic [31:0] x, input logic [31:0] y, output logic in_x);
    drive_check(v, r, op, x, y);
    commit(in_x);
  endtask

  // One op through an empty pipe with hand-computed N=8 expectations.
  task automatic lit(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] ez, input logic ezero, input logic eones);
    logic ix;
    step(1'b1, 1'b1, op, 32'(x), 32'(y), ix);
    step(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, ix);
    drive_check(1'b0, 1'b1, 3'd0, 32'd0, 32'd0);
    chk("lit_valid", 8, 32'(ov[1]), 32'd1);
    chk("lit_z", 8, z_w[1], 32'(ez));
    chk("lit_zero", 8, 32'(zf[1]), 32'(ezero));
    chk("lit_ones", 8, 32'(of[1]), 32'(eones));
    commit(ix);
  endtask

  task automatic reset_checks(string nm);
    for (int i = 0; i < NW; i++) begin
      chk({nm, "_valid"}, WID[i], 32'(ov[i]), 32'd0);
      chk({nm, "_ready"}, WID[i], 32'(ordy[i]), 32'd1);
      chk({nm, "_z"}, WID[i], z_w[i], 32'd0);
      chk({nm, "_zero"}, WID[i], 32'(zf[i]), 32'd0);
      chk({nm, "_ones"}, WID[i], 32'(of[i]), 32'd0);
    end
  endtask

  initial begin
    logic        ix;
    logic [2:0]  bp_op [3];
    logic [31:0] bp_x [3];
    logic [31:0] bp_y [3];
    int          idx;
    int          acc;

    rst_n    = 1'b0;
    tb_valid = 1'b0;
    tb_ready = 1'b0;
    tb_op    = 3'd0;
    tb_x     = 32'd0;
    tb_y     = 32'd0;
    #2;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;

    lit(LU_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    lit(LU_XOR,  8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0);
    lit(LU_NOR,  8'h00, 8'h00, 8'hFF, 1'b0, 1'b1);
    lit(LU_ANDN, 8'hF0, 8'h3C, 8'hC0, 1'b0, 1'b0);
    lit(LU_PASS, 8'h5A, 8'h77, 8'h5A, 1'b0, 1'b0);
    lit(LU_OR,   8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b1);
    lit(LU_NAND, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
    lit(LU_XNOR, 8'hA5, 8'h5A, 8'h00, 1'b1, 1'b0);

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, ix);
      chk("stream_accept", 8, 32'(ix), 32'd1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, ix);

    // Consumer stalled for five cycles while three ops are offered.
    bp_op = '{LU_XOR, LU_OR, LU_ANDN};
    for (int i = 0; i < 3; i++) begin
      bp_x[i] = $urandom;
      bp_y[i] = $urandom;
    end
    idx = 0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      int j;
      j = (idx > 2) ? 2 : idx;
      drive_check(idx < 3, c >= 5, bp_op[j], bp_x[j], bp_y[j]);
      if (c < 5 && tb_valid && ordy[1]) acc++;
      commit(ix);
      if (ix) idx++;
    end
    chk("bp_accepts_while_stalled", 8, 32'(acc), 32'd2);
    chk("bp_all_accepted", 8, 32'(idx), 32'd3);

    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           3'($urandom_range(0, 7)), $urandom, $urandom, ix);
    end

    // Fill the pipe against a stalled consumer, then reset between edges.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, ix);
    @(negedge clk);
    #2;
    chk("full_before_reset", 8, 32'(ov[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    reset_checks("async_rst");
    q.delete();
    tb_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           3'($urandom_range(0, 7)), $urandom, $urandom, ix);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, ix);
    chk("drained", 8, 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
